local_store: RTL and testbench
==============================

LOCAL_STORE -- requirements
Module: local_store

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 6, cycles from accepted read to ls_data_valid (legal 1..8).
REQ-002 SHALL have parameter LS_LINES, default 2048, number of 128-bit quadword lines (32 KB).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ls_req  input  1  data-port request from odd pipe (load or store).
REQ-006 SHALL have port ls_wrt_en  input  1  with ls_req: 1 = store, 0 = load.
REQ-007 SHALL have port ls_address  input  15  byte address, bits [0:14], big-endian numbering.
REQ-008 SHALL have port ls_data_input  input  128  store data, bits [0:127].
REQ-009 SHALL have port ls_data_output  output  128  load data, bits [0:127].
REQ-010 SHALL have port ls_data_valid  output  1  ls_data_output holds a load result this cycle.
REQ-011 SHALL have port if_req  input  1  instruction-fetch read request.
REQ-012 SHALL have port if_address  input  15  fetch byte address.
REQ-013 SHALL have port if_grant  output  1  fetch request accepted this cycle (combinational).
REQ-014 SHALL have port if_data  output  128  fetched quadword.
REQ-015 SHALL have port if_data_valid  output  1  if_data valid this cycle.
REQ-016 SHALL have port ls_ready  output  1  block accepts requests.

Function
REQ-017 SHALL ignore address bits [11:14]; line index = ls_address[0:10] (quadword aligned).
REQ-018 SHALL give the data port strict priority; if_grant = if_req & ls_ready & ~ls_req.
REQ-019 SHALL commit a store at the request edge; no response is issued for stores.
REQ-020 SHALL sample array contents at the accept edge; a store issued after an accepted load does not alter that load's data.
REQ-021 SHALL return a load accepted in cycle N in cycle N+RD_LATENCY with ls_data_valid=1 for exactly one cycle; same for fetch on if_data_valid.
REQ-022 SHALL be fully pipelined: one data and, when data port idle, one fetch accepted per cycle, back-to-back.
REQ-023 SHALL give a load in cycle N+1 the data of a store to the same line in cycle N.
REQ-024 SHALL drive ls_data_output and if_data to zero when their valid is low.
REQ-025 SHALL ignore ls_req and if_req while ls_ready=0 (no grant, no store, no response).
REQ-026 SHALL treat line LS_LINES-1 (address 15'h7FF0..7FFF) as an ordinary line; no wrap beyond it.

Reset
REQ-027 SHALL on reset clear all in-flight pipeline valids; no response for requests accepted before reset.
REQ-028 SHALL hold ls_data_valid, if_data_valid, if_grant at 0 and data outputs at zero during reset.
REQ-029 SHALL leave array contents unchanged by reset unless LS_CLEAR_EN is defined.
REQ-030 SHALL assert ls_ready in the first cycle after reset deasserts when LS_CLEAR_EN is undefined.

Configuration
REQ-031 SHALL with LS_CLEAR_EN defined run FSM READY->CLEAR on reset; CLEAR writes zero to one line per cycle, line 0 upward.
REQ-032 SHALL with LS_CLEAR_EN hold ls_ready=0 in CLEAR, move to READY after line LS_LINES-1 is written (LS_LINES cycles after reset release); reset during CLEAR restarts at line 0.
REQ-033 SHALL without LS_CLEAR_EN contain no clear FSM or counter.

Structure
REQ-034 SHALL take LS_ADDR_W=15, QW_W=128 and the line-index width from shared package descriptions.
REQ-035 SHALL instantiate sub-module ls_read_pipe twice (data, fetch): RD_LATENCY-stage valid+data delay line with synchronous clear.

Verification
REQ-036 SHALL cover: store 128'hDEADBEEF_0123_4567_89AB_CDEF_0011_2233 at 15'h0050, load 15'h0057 next cycle -> same value, ls_data_valid exactly 6 cycles later.
REQ-037 SHALL cover: ls_req load and if_req same cycle -> if_grant=0; fetch regranted next cycle, if_data_valid 6 cycles after that.
REQ-038 SHALL cover: loads to 15'h0000,15'h0010,15'h0020 back-to-back -> three consecutive valid cycles, data in order.
REQ-039 SHALL cover: load accepted, reset asserted 2 cycles later -> ls_data_valid never rises for it.
REQ-040 SHALL cover: store/load at 15'h7FF0 -> value returned, line 0 unchanged.
REQ-041 SHALL cover (LS_CLEAR_EN): reset release -> ls_ready=0 for 2048 cycles, then load of any line returns 128'h0.

Source files
------------

// File: rtl/local_store_pkg.sv
// local_store_pkg: shared widths and state encoding for the local store.
package local_store_pkg;
  localparam int LS_ADDR_W = 15;
  localparam int QW_W = 128;
  localparam int LINE_W = 11;
  typedef enum logic {ST_READY, ST_CLEAR} ls_state_e;
endpackage

// File: rtl/local_store_read_pipe.sv
// ls_read_pipe: DEPTH-stage valid+data delay line; rst clears only the valids.
module ls_read_pipe #(
  parameter int DEPTH = 6,
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic [DEPTH-1:0] v;
  logic [W-1:0] d [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) v <= '0;
    else begin
      v[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) v[i] <= v[i-1];
    end
    d[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) d[i] <= d[i-1];
  end
  assign out_valid = v[DEPTH-1];
  assign out_data = d[DEPTH-1];
endmodule

// File: rtl/local_store.sv
// local_store: 128-bit line store with priority data port and fetch port.
// Define LS_CLEAR_EN to zero the array line by line after every reset.
module local_store
  import local_store_pkg::*;
#(
  parameter int RD_LATENCY = 6,
  parameter int LS_LINES = 2048
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ls_req,
  input  logic              ls_wrt_en,
  input  logic [0:LS_ADDR_W-1] ls_address,
  input  logic [0:QW_W-1]   ls_data_input,
  output logic [0:QW_W-1]   ls_data_output,
  output logic              ls_data_valid,
  input  logic              if_req,
  input  logic [0:LS_ADDR_W-1] if_address,
  output logic              if_grant,
  output logic [0:QW_W-1]   if_data,
  output logic              if_data_valid,
  output logic              ls_ready
);
  logic [0:QW_W-1] mem [LS_LINES];
  logic [LINE_W-1:0] ls_idx, if_idx, wr_idx;
  logic [0:QW_W-1] wr_data, ls_d, if_d;
  logic ls_acc, store, load, wr_en, ls_v, if_v;
  logic unused;
  assign unused = ^{ls_address[LINE_W:LS_ADDR_W-1], if_address[LINE_W:LS_ADDR_W-1]};
  assign ls_idx = ls_address[0:LINE_W-1];
  assign if_idx = if_address[0:LINE_W-1];
  assign ls_acc = ls_req & ls_ready;
  assign store = ls_acc & ls_wrt_en;
  assign load = ls_acc & ~ls_wrt_en;
  assign if_grant = if_req & ls_ready & ~ls_req;
`ifdef LS_CLEAR_EN
  ls_state_e state;
  logic [LINE_W-1:0] clr_idx;
  logic ready_q, clearing;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_CLEAR;
      clr_idx <= '0;
      ready_q <= 1'b0;
    end else if (state == ST_CLEAR) begin
      clr_idx <= clr_idx + LINE_W'(1);
      state <= (clr_idx == LINE_W'(LS_LINES - 1)) ? ST_READY : ST_CLEAR;
      ready_q <= (clr_idx == LINE_W'(LS_LINES - 1));
    end
  end
  assign clearing = (state == ST_CLEAR) & ~reset;
  assign ls_ready = ready_q & ~reset;
  assign wr_en = clearing | store;
  assign wr_idx = clearing ? clr_idx : ls_idx;
  assign wr_data = clearing ? '0 : ls_data_input;
`else
  assign ls_ready = ~reset;
  assign wr_en = store;
  assign wr_idx = ls_idx;
  assign wr_data = ls_data_input;
`endif
  always_ff @(posedge clock) if (wr_en) mem[wr_idx] <= wr_data;
  // reads capture the array at the accept edge, so later stores cannot leak in
  ls_read_pipe #(.DEPTH(RD_LATENCY), .W(QW_W)) u_ls_pipe (
    .clk(clock), .rst(reset), .in_valid(load), .in_data(mem[ls_idx]),
    .out_valid(ls_v), .out_data(ls_d)
  );
  ls_read_pipe #(.DEPTH(RD_LATENCY), .W(QW_W)) u_if_pipe (
    .clk(clock), .rst(reset), .in_valid(if_grant), .in_data(mem[if_idx]),
    .out_valid(if_v), .out_data(if_d)
  );
  assign ls_data_valid = ls_v & ~reset;
  assign if_data_valid = if_v & ~reset;
  assign ls_data_output = ls_data_valid ? ls_d : '0;
  assign if_data = if_data_valid ? if_d : '0;
endmodule

// File: tb/tb_local_store.sv
// tb_local_store: random and directed checks of local_store against a queue-based model.
module tb_local_store;
  localparam int LAT = 6;
  localparam int LINES = 2048;
`ifdef LS_CLEAR_EN
  localparam int CLR_CYC = LINES;
`else
  localparam int CLR_CYC = 0;
`endif
  typedef struct {int due; logic [127:0] d;} rsp_t;
  logic clock = 0;
  logic reset, ls_req, ls_wrt_en, if_req;
  logic [14:0] ls_address, if_address;
  logic [127:0] ls_data_input;
  logic [127:0] ls_data_output, if_data;
  logic ls_data_valid, if_grant, if_data_valid, ls_ready;
  logic [127:0] model [LINES];
  rsp_t lsq[$], ifq[$];
  int cyc = 0, wait_n = CLR_CYC, n_checks = 0, n_fail = 0;
  logic ev_ls = 0, ev_if = 0;
  logic [127:0] ed_ls = '0, ed_if = '0;
  logic [259:0] exp_vec;
  wire [259:0] obs = {ls_ready, if_grant, ls_data_valid, ls_data_output, if_data_valid, if_data};

  local_store #(.RD_LATENCY(LAT), .LS_LINES(LINES)) dut (
    .clock(clock), .reset(reset), .ls_req(ls_req), .ls_wrt_en(ls_wrt_en),
    .ls_address(ls_address), .ls_data_input(ls_data_input),
    .ls_data_output(ls_data_output), .ls_data_valid(ls_data_valid),
    .if_req(if_req), .if_address(if_address), .if_grant(if_grant),
    .if_data(if_data), .if_data_valid(if_data_valid), .ls_ready(ls_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input logic lr, input logic lw, input logic [14:0] la, input logic [127:0] ld,
                       input logic ir, input logic [14:0] ia, input logic rs);
    logic xr, xl, xi;
    reset = rs; ls_req = lr; ls_wrt_en = lw; ls_address = la; ls_data_input = ld;
    if_req = ir; if_address = ia;
    #1;
    xr = !rs && wait_n == 0;
    xl = ev_ls && !rs;
    xi = ev_if && !rs;
    exp_vec = {xr, ir && !lr && xr, xl, xl ? ed_ls : 128'h0, xi, xi ? ed_if : 128'h0};
  endtask

  task automatic tick();
    logic rdy;
    rdy = !reset && wait_n == 0;
    @(posedge clock);
    if (reset) begin
      lsq.delete(); ifq.delete();
      wait_n = CLR_CYC;
      if (CLR_CYC > 0) foreach (model[i]) model[i] = '0;
    end else begin
      if (wait_n > 0) wait_n--;
      if (rdy && ls_req) begin
        if (ls_wrt_en) model[ls_address[14:4]] = ls_data_input;
        else lsq.push_back('{cyc + LAT, model[ls_address[14:4]]});
      end else if (rdy && if_req) ifq.push_back('{cyc + LAT, model[if_address[14:4]]});
    end
    cyc++;
    ev_ls = lsq.size() > 0 && lsq[0].due == cyc;
    ed_ls = ev_ls ? lsq[0].d : '0;
    if (ev_ls) void'(lsq.pop_front());
    ev_if = ifq.size() > 0 && ifq[0].due == cyc;
    ed_if = ev_if ? ifq[0].d : '0;
    if (ev_if) void'(ifq.pop_front());
    @(negedge clock);
  endtask

  task automatic test_reset();
    int low = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 15'($urandom), 128'h0, 1, 15'($urandom), 1);
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL reset cyc %0d got %h want %h", cyc, obs, exp_vec); end
      tick();
    end
    for (int i = 0; i < CLR_CYC + 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL reset_release cyc %0d got %h want %h", cyc, obs, exp_vec); end
      if (!ls_ready) low++;
      tick();
    end
    n_checks++;
    if (low != CLR_CYC) begin n_fail++; $display("FAIL ready_low_cycles got %0d want %0d", low, CLR_CYC); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < LINES; i++) begin
      drive(1, 1, 15'((i << 4) | $urandom_range(0, 15)), r128(), 1'($urandom), 15'($urandom), 0);
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL fill cyc %0d got %h want %h", cyc, obs, exp_vec); end
      tick();
    end
  endtask

  task automatic test_store_load();
    logic [127:0] k, got;
    int lc, seen = -1;
    k = 128'hDEADBEEF_0123_4567_89AB_CDEF_0011_2233;
    got = '0;
    for (int i = 0; i < LAT + 4; i++) begin
      if (i == 0) drive(1, 1, 15'h0050, k, 0, 0, 0);
      else if (i == 1) begin drive(1, 0, 15'h0057, r128(), 0, 0, 0); lc = cyc; end
      else drive(0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL store_load cyc %0d got %h want %h", cyc, obs, exp_vec); end
      if (ls_data_valid) begin seen = cyc; got = ls_data_output; end
      tick();
    end
    n_checks++;
    if (seen != lc + LAT || got !== k)
      begin n_fail++; $display("FAIL store_load_result got cyc %0d data %h want cyc %0d data %h", seen, got, lc + LAT, k); end
  endtask

  task automatic test_priority();
    int gc = -1, vc = -1;
    logic [127:0] got = '0;
    for (int i = 0; i < LAT + 4; i++) begin
      if (i == 0) drive(1, 0, 15'h0100, 0, 1, 15'h0200, 0);
      else if (i == 1) drive(0, 0, 0, 0, 1, 15'h0200, 0);
      else drive(0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL priority cyc %0d got %h want %h", cyc, obs, exp_vec); end
      if (i == 0) begin
        n_checks++;
        if (if_grant !== 1'b0) begin n_fail++; $display("FAIL priority_grant got %b want 0", if_grant); end
      end
      if (if_grant && gc < 0) gc = cyc;
      if (if_data_valid) begin vc = cyc; got = if_data; end
      tick();
    end
    n_checks++;
    if (gc < 0 || vc != gc + LAT || got !== model[11'h020])
      begin n_fail++; $display("FAIL fetch_regrant got grant %0d valid %0d data %h want valid %0d data %h", gc, vc, got, gc + LAT, model[11'h020]); end
  endtask

  task automatic test_back_to_back();
    int c0 = 0;
    int gc[$];
    logic [127:0] got[$];
    for (int i = 0; i < LAT + 5; i++) begin
      if (i < 3) drive(1, 0, 15'(i * 16), 0, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0, 0);
      if (i == 0) c0 = cyc;
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL back_to_back cyc %0d got %h want %h", cyc, obs, exp_vec); end
      if (ls_data_valid) begin gc.push_back(cyc); got.push_back(ls_data_output); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= gc.size() || gc[i] != c0 + LAT + i || got[i] !== model[i])
        begin n_fail++; $display("FAIL back_to_back_order idx %0d got %0d responses want cyc %0d data %h", i, gc.size(), c0 + LAT + i, model[i]); end
    end
  endtask

  task automatic test_reset_flight();
    int vs = 0;
    for (int i = 0; i < 5 + CLR_CYC + LAT; i++) begin
      if (i == 0) drive(1, 0, 15'h0030, 0, 1, 15'h0040, 0);
      else if (i == 3 || i == 4) drive(0, 0, 0, 0, 0, 0, 1);
      else drive(0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL reset_flight cyc %0d got %h want %h", cyc, obs, exp_vec); end
      if (ls_data_valid) vs++;
      tick();
    end
    n_checks++;
    if (vs != 0) begin n_fail++; $display("FAIL reset_flight_valid got %0d responses want 0", vs); end
  endtask

  task automatic test_top_line();
    logic [127:0] v, l0;
    logic [127:0] got[$];
    v = r128();
    l0 = model[0];
    for (int i = 0; i < LAT + 5; i++) begin
      if (i == 0) drive(1, 1, 15'h7FF0, v, 0, 0, 0);
      else if (i == 1) drive(1, 0, 15'h7FF0, 0, 0, 0, 0);
      else if (i == 2) drive(1, 0, 15'h0000, 0, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL top_line cyc %0d got %h want %h", cyc, obs, exp_vec); end
      if (ls_data_valid) got.push_back(ls_data_output);
      tick();
    end
    n_checks++;
    if (got.size() != 2 || got[0] !== v || got[1] !== l0)
      begin n_fail++; $display("FAIL top_line_data got %0d responses want %h then %h", got.size(), v, l0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400 + LAT + 2; i++) begin
      if (i < 400) drive(1'($urandom), 1'($urandom), 15'($urandom), r128(), 1'($urandom), 15'($urandom), 0);
      else drive(0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL random cyc %0d got %h want %h", cyc, obs, exp_vec); end
      tick();
    end
  endtask

`ifdef LS_CLEAR_EN
  task automatic test_clear();
    int low = 0, nz = 0;
    for (int i = 0; i < 103; i++) begin
      drive(1'($urandom), 1'($urandom), 15'($urandom), r128(), 0, 0, (i == 0 || i == 101));
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL clear_restart cyc %0d got %h want %h", cyc, obs, exp_vec); end
      tick();
    end
    for (int i = 0; i < CLR_CYC + 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      if (!ls_ready) low++;
      tick();
    end
    n_checks++;
    if (low != CLR_CYC - 1) begin n_fail++; $display("FAIL clear_ready_low got %0d want %0d", low, CLR_CYC - 1); end
    for (int i = 0; i < 20 + LAT + 2; i++) begin
      if (i < 20) drive(1, 0, 15'($urandom), 0, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL clear_load cyc %0d got %h want %h", cyc, obs, exp_vec); end
      if (ls_data_valid && ls_data_output !== 128'h0) nz++;
      tick();
    end
    n_checks++;
    if (nz != 0) begin n_fail++; $display("FAIL clear_zero got %0d nonzero loads want 0", nz); end
  endtask
`endif

  initial begin
    reset = 1; ls_req = 0; ls_wrt_en = 0; if_req = 0;
    ls_address = '0; if_address = '0; ls_data_input = '0;
    foreach (model[i]) model[i] = '0;
    @(negedge clock);
    test_reset();
    test_fill();
    test_store_load();
    test_priority();
    test_back_to_back();
    test_reset_flight();
    test_top_line();
    test_random();
`ifdef LS_CLEAR_EN
    test_clear();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
